// File: rtl/rvvi_stream_pkg.sv
// Shared types and helpers for the RVVI retire-event stream.
// Event fields are sized for the widest supported ILEN/XLEN (64) and zero-extended.
package rvvi_stream_pkg;

  localparam int MAX_RETIRE = 4;
  localparam int SLOT_W     = 3;
  localparam int MAX_ILEN   = 64;
  localparam int MAX_XLEN   = 64;

  typedef struct packed {
    logic [63:0]         order;
    logic [MAX_ILEN-1:0] insn;
    logic [MAX_XLEN-1:0] pc;
    logic                trap;
    logic [1:0]          mode;
    logic                order_err;
  } rvvi_event_t;

  function automatic logic [SLOT_W-1:0] popcount(input logic [MAX_RETIRE-1:0] v);
    logic [SLOT_W-1:0] c;
    c = 3'd0;
    for (int i = 0; i < MAX_RETIRE; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/rvvi_lane_compactor.sv
// Prefix-sum over the per-lane valid bits: gives each valid lane its slot
// offset from the write pointer, and the number of valid lanes.
module rvvi_lane_compactor
  import rvvi_stream_pkg::*;
#(
  parameter int RETIRE = 2
) (
  input  logic [RETIRE-1:0]             valid,
  output logic [RETIRE-1:0][SLOT_W-1:0] offset,
  output logic [SLOT_W-1:0]             count
);

  // running slot offset per lane and total valid count
  always_comb begin
    logic [SLOT_W-1:0] acc;
    acc = 3'd0;
    for (int i = 0; i < RETIRE; i++) begin
      offset[i] = acc;
      acc       = acc + {2'b00, valid[i]};
    end
    count = popcount(MAX_RETIRE'(valid));
  end

endmodule

// File: rtl/rvvi_retire_serializer.sv
// Compacts one hart's RVVI retire lanes into a FIFO and replays them one per
// cycle; the trace cannot stall, so groups that do not fit are dropped whole.
module rvvi_retire_serializer
  import rvvi_stream_pkg::*;
#(
  parameter int          ILEN        = 32,
  parameter int          XLEN        = 32,
  parameter int          RETIRE      = 2,
  parameter int          DEPTH       = 8,
  parameter logic [63:0] FIRST_ORDER = 64'd1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RETIRE-1:0]          in_valid,
  input  logic [RETIRE*64-1:0]       in_order,
  input  logic [RETIRE*ILEN-1:0]     in_insn,
  input  logic [RETIRE*XLEN-1:0]     in_pc,
  input  logic [RETIRE-1:0]          in_trap,
  input  logic [RETIRE*2-1:0]        in_mode,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_order,
  output logic [ILEN-1:0]            out_insn,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_trap,
  output logic [1:0]                 out_mode,
  output logic                       out_order_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [31:0]                drop_count,
  output logic                       overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  rvvi_event_t mem [DEPTH];

  logic [PW-1:0]  wptr_r;
  logic [PW-1:0]  rptr_r;
  logic [LW-1:0]  level_r;
  logic [63:0]    expected_r;
  logic [31:0]    drop_count_r;
  logic           overflow_r;

  logic [RETIRE-1:0][SLOT_W-1:0] offset_s;
  logic [SLOT_W-1:0]             count_s;
  logic [LW-1:0]                 free_s;
  logic                          accept_s;
  logic                          pop_s;
  logic [LW-1:0]                 level_next_s;
  logic [32:0]                   drop_sum_s;
  logic [63:0]                   exp_next_s;
  rvvi_event_t                   lane_ev_s [RETIRE];
  rvvi_event_t                   head_s;

  rvvi_lane_compactor #(.RETIRE(RETIRE)) u_compactor (
    .valid  (in_valid),
    .offset (offset_s),
    .count  (count_s)
  );

  // admission uses the level at cycle start; a same-cycle pop frees nothing
  always_comb begin
    free_s       = LW'(DEPTH) - level_r;
    accept_s     = (32'(count_s) <= 32'(free_s));
    pop_s        = (level_r != {LW{1'b0}}) && out_ready;
    drop_sum_s   = {1'b0, drop_count_r} + 33'(count_s);
    if (accept_s) begin
      level_next_s = level_r + LW'(count_s) - LW'(pop_s);
    end else begin
      level_next_s = level_r - LW'(pop_s);
    end
  end

  // order check resyncs after every valid lane, accepted or dropped
  always_comb begin
    logic [63:0] exp_v;
    exp_v = expected_r;
    for (int i = 0; i < RETIRE; i++) begin
      lane_ev_s[i].order = in_order[i*64 +: 64];
      lane_ev_s[i].insn  = MAX_ILEN'(in_insn[i*ILEN +: ILEN]);
      lane_ev_s[i].pc    = MAX_XLEN'(in_pc[i*XLEN +: XLEN]);
      lane_ev_s[i].trap  = in_trap[i];
      lane_ev_s[i].mode  = in_mode[i*2 +: 2];
      if (in_valid[i]) begin
        lane_ev_s[i].order_err = (in_order[i*64 +: 64] != exp_v);
        exp_v                  = in_order[i*64 +: 64] + 64'd1;
      end else begin
        lane_ev_s[i].order_err = 1'b0;
      end
    end
    exp_next_s = exp_v;
  end

  // FIFO storage: valid lanes land at consecutive slots from wptr
  always_ff @(posedge clk) begin
    for (int i = 0; i < RETIRE; i++) begin
      if (!reset && accept_s && in_valid[i]) begin
        mem[wptr_r + PW'(offset_s[i])] <= lane_ev_s[i];
      end
    end
  end

  // pointers, occupancy, order tracking and drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r       <= {PW{1'b0}};
      rptr_r       <= {PW{1'b0}};
      level_r      <= {LW{1'b0}};
      expected_r   <= FIRST_ORDER;
      drop_count_r <= 32'd0;
      overflow_r   <= 1'b0;
    end else begin
      expected_r <= exp_next_s;
      level_r    <= level_next_s;
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      if (accept_s) begin
        wptr_r <= wptr_r + PW'(count_s);
      end else begin
        overflow_r   <= 1'b1;
        drop_count_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
      end
    end
  end

  // head fields read as zero while the FIFO is empty
  always_comb begin
    if (level_r != {LW{1'b0}}) begin
      head_s = mem[rptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign out_valid     = (level_r != {LW{1'b0}});
  assign in_ready      = (32'(free_s) >= 32'(RETIRE));
  assign out_order     = head_s.order;
  assign out_insn      = head_s.insn[ILEN-1:0];
  assign out_pc        = head_s.pc[XLEN-1:0];
  assign out_trap      = head_s.trap;
  assign out_mode      = head_s.mode;
  assign out_order_err = head_s.order_err;
  assign level         = level_r;
  assign drop_count    = drop_count_r;
  assign overflow      = overflow_r;

endmodule
